// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding request/ack transaction on the
// data-memory port, with store byte-lane steering and load extension.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              mem_read,
  input  logic              mem_wr,
  input  logic [1:0]        store_size,
  input  logic [2:0]        load_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              access_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wd_q;
  logic [2:0]        ext_q;
  logic [1:0]        off_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic        code_ok;
  logic        align_ok;
  logic        access_legal;
  logic        access_bad;
  logic [3:0]  be_s;
  logic [31:0] wd_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_val;

  // Decode size/alignment legality and the steered lanes for the incoming access.
  always_comb begin
    code_ok  = 1'b0;
    align_ok = 1'b0;
    be_s     = 4'b1111;
    wd_s     = 32'h0;
    if (mem_wr && !mem_read) begin
      case (store_size)
        2'b00: begin
          code_ok  = 1'b1;
          align_ok = (addr[1:0] == 2'b00);
          be_s     = 4'b1111;
          wd_s     = wdata;
        end
        2'b01: begin
          code_ok  = 1'b1;
          align_ok = !addr[0];
          be_s     = addr[1] ? 4'b1100 : 4'b0011;
          wd_s     = {2{wdata[15:0]}};
        end
        2'b10: begin
          code_ok  = 1'b1;
          align_ok = 1'b1;
          be_s     = 4'b0001 << addr[1:0];
          wd_s     = {4{wdata[7:0]}};
        end
        default: begin
          code_ok  = 1'b0;
          align_ok = 1'b0;
        end
      endcase
    end else if (mem_read && !mem_wr) begin
      case (load_ext)
        3'b000: begin
          code_ok  = 1'b1;
          align_ok = (addr[1:0] == 2'b00);
        end
        3'b001, 3'b010: begin
          code_ok  = 1'b1;
          align_ok = !addr[0];
        end
        3'b011, 3'b100: begin
          code_ok  = 1'b1;
          align_ok = 1'b1;
        end
        default: begin
          code_ok  = 1'b0;
          align_ok = 1'b0;
        end
      endcase
    end
  end

  assign access_legal = issue && code_ok && align_ok;
  assign access_bad   = issue && (mem_read || mem_wr) && !access_legal;

  // Load extraction uses the offset and type latched at issue time.
  always_comb begin
    case (off_q)
      2'd0:    byte_s = dm_rdata[7:0];
      2'd1:    byte_s = dm_rdata[15:8];
      2'd2:    byte_s = dm_rdata[23:16];
      default: byte_s = dm_rdata[31:24];
    endcase
    half_s = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (ext_q)
      3'b001:  load_val = {{16{half_s[15]}}, half_s};
      3'b010:  load_val = {16'h0, half_s};
      3'b011:  load_val = {{24{byte_s[7]}}, byte_s};
      3'b100:  load_val = {24'h0, byte_s};
      default: load_val = dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access_legal) state_d = ST_REQ;
      ST_REQ:  if (dm_ack) state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake: dm_req stays high with every dm_* output frozen until dm_ack is
  // sampled high on a rising edge; that edge completes the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0;
      ext_q   <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == ST_IDLE) && access_bad;
      if (state_q == ST_IDLE && access_legal) begin
        addr_q <= {addr[ADDR_W-1:2], 2'b00};
        we_q   <= mem_wr;
        be_q   <= be_s;
        wd_q   <= wd_s;
        ext_q  <= load_ext;
        off_q  <= addr[1:0];
      end
      if (state_q == ST_REQ && dm_ack && !we_q) begin
        rdata_q <= load_val;
      end
    end
  end

  // Request is decoded from state so an asynchronous reset drops it at once.
  assign dm_req     = (state_q == ST_REQ);
  assign done       = (state_q == ST_RESP);
  assign dm_we      = we_q;
  assign dm_addr    = addr_q;
  assign dm_be      = be_q;
  assign dm_wdata   = wd_q;
  assign rdata      = rdata_q;
  assign access_err = err_q;
  assign dbg_state  = state_q;
  assign stall      = !rst && (((state_q == ST_IDLE) && access_legal) || (state_q == ST_REQ));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus multi-cycle sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue, mem_read, mem_wr;
  logic [1:0]  store_size;
  logic [2:0]  load_ext;
  logic [31:0] addr, wdata;
  logic        stall, done, access_err;
  logic [31:0] rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_rdata = 32'h0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .issue(issue), .mem_read(mem_read), .mem_wr(mem_wr),
    .store_size(store_size), .load_ext(load_ext), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .done(done), .access_err(access_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [2:0]  ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic        err;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [2:0] ext, input logic [31:0] a, input logic [31:0] wd);
    issue = 1'b1; mem_read = rd; mem_wr = wr;
    store_size = sz; load_ext = ext; addr = a; wdata = wd;
  endtask

  task automatic idle_in();
    issue = 1'b0; mem_read = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.rd, v.wr, v.size, v.ext, v.addr, v.wdata);
    sample();
    chk($sformatf("v%0d_stall0", idx), {31'h0, stall}, {31'h0, !v.err});
    tick();
    idle_in();
    if (v.err) begin
      sample();
      chk($sformatf("v%0d_err", idx), {31'h0, access_err}, 32'h1);
      chk($sformatf("v%0d_noreq", idx), {31'h0, dm_req}, 32'h0);
      chk($sformatf("v%0d_nostall", idx), {31'h0, stall}, 32'h0);
      tick();
      sample();
      chk($sformatf("v%0d_err_clear", idx), {31'h0, access_err}, 32'h0);
      chk($sformatf("v%0d_idle", idx), {30'h0, dbg_state}, 32'h0);
      tick();
    end else begin
      dm_ack = 1'b1;
      dm_rdata = v.mrd;
      sample();
      chk($sformatf("v%0d_req", idx), {31'h0, dm_req}, 32'h1);
      chk($sformatf("v%0d_we", idx), {31'h0, dm_we}, {31'h0, v.wr});
      chk($sformatf("v%0d_addr", idx), dm_addr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_be", idx), {28'h0, dm_be}, {28'h0, v.be});
      if (v.wr) chk($sformatf("v%0d_wdata", idx), dm_wdata, v.ewd);
      chk($sformatf("v%0d_stall1", idx), {31'h0, stall}, 32'h1);
      tick();
      dm_ack = 1'b0;
      dm_rdata = 32'h0;
      sample();
      if (v.rd) model_rdata = v.erd;
      chk($sformatf("v%0d_done", idx), {31'h0, done}, 32'h1);
      chk($sformatf("v%0d_stall2", idx), {31'h0, stall}, 32'h0);
      chk($sformatf("v%0d_req_low", idx), {31'h0, dm_req}, 32'h0);
      chk($sformatf("v%0d_rdata", idx), rdata, model_rdata);
      tick();
      sample();
      chk($sformatf("v%0d_done_clear", idx), {31'h0, done}, 32'h0);
      chk($sformatf("v%0d_back_idle", idx), {30'h0, dbg_state}, 32'h0);
      tick();
    end
  endtask

  initial begin
    //          rd    wr    size   ext     addr          wdata          mrd            err   be       ewd            erd
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0,         1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_2002, 32'h0,         32'h8001_1234, 1'b0, 4'b1111, 32'h0,         32'hFFFF_8001};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_2002, 32'h0,         32'h8001_1234, 1'b0, 4'b1111, 32'h0,         32'h0000_8001};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 3'b100, 32'h0000_2001, 32'h0,         32'h8001_1234, 1'b0, 4'b1111, 32'h0,         32'h0000_0012};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 3'b011, 32'h0000_2003, 32'h0,         32'h8001_1234, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FF80};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_3000, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_1002, 32'h1234_ABCD, 32'h0,         1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_4000, 32'h1234_5678, 32'h0,         1'b0, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_3002, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 3'b000, 32'h0000_3000, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 3'b101, 32'h0000_3000, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_1001, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 1'b1, 2'b11, 3'b000, 32'h0000_1000, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 3'b011, 32'h0000_2000, 32'h0,         32'h0000_007F, 1'b0, 4'b1111, 32'h0,         32'h0000_007F};
    vecs[14] = '{1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_1000, 32'h0000_005A, 32'h0,         1'b0, 4'b0001, 32'h5A5A_5A5A, 32'h0};

    // Reset with a legal load presented: everything must read zero.
    rst = 1'b1;
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_3000, 32'h0);
    sample();
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req", {31'h0, dm_req}, 32'h0);
    chk("rst_addr", dm_addr, 32'h0);
    chk("rst_be", {28'h0, dm_be}, 32'h0);
    chk("rst_wdata", dm_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {29'h0, done, access_err, dm_we}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    rst = 1'b0;
    idle_in();
    tick();

    // No-op issue: no stall, no state change.
    issue = 1'b1;
    sample();
    chk("nop_stall", {31'h0, stall}, 32'h0);
    tick();
    sample();
    chk("nop_state", {30'h0, dbg_state}, 32'h0);
    chk("nop_err", {31'h0, access_err}, 32'h0);
    idle_in();
    tick();

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // SW with ack at cycle 4: outputs stable, stall for cycles 0..4, one done.
    begin
      int stall_cnt = 0;
      int done_cnt = 0;
      drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_4000, 32'h1122_3344);
      sample();
      if (stall) stall_cnt++;
      tick();
      idle_in();
      for (int c = 1; c <= 4; c++) begin
        dm_ack = (c == 4);
        sample();
        chk($sformatf("sw_wait_req_c%0d", c), {31'h0, dm_req}, 32'h1);
        chk($sformatf("sw_wait_addr_c%0d", c), dm_addr, 32'h0000_4000);
        chk($sformatf("sw_wait_be_c%0d", c), {28'h0, dm_be}, 32'hF);
        chk($sformatf("sw_wait_wdata_c%0d", c), dm_wdata, 32'h1122_3344);
        if (stall) stall_cnt++;
        if (done) done_cnt++;
        tick();
      end
      dm_ack = 1'b0;
      for (int c = 5; c <= 7; c++) begin
        sample();
        if (stall) stall_cnt++;
        if (done) done_cnt++;
        if (c == 5) chk("sw_wait_done_c5", {31'h0, done}, 32'h1);
        tick();
      end
      chk("sw_wait_stall_cycles", stall_cnt, 32'd5);
      chk("sw_wait_done_count", done_cnt, 32'd1);
      chk("sw_wait_rdata_kept", rdata, model_rdata);
    end

    // Reset during REQ: request drops at once, ack afterwards is ignored.
    begin
      int done_cnt = 0;
      drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_5000, 32'h0);
      tick();
      idle_in();
      sample();
      chk("rstreq_req_before", {31'h0, dm_req}, 32'h1);
      #2 rst = 1'b1;
      dm_ack = 1'b1;
      dm_rdata = 32'h1357_9BDF;
      #1;
      chk("rstreq_req_async", {31'h0, dm_req}, 32'h0);
      chk("rstreq_stall", {31'h0, stall}, 32'h0);
      chk("rstreq_state", {30'h0, dbg_state}, 32'h0);
      tick();
      rst = 1'b0;
      model_rdata = 32'h0;
      for (int c = 0; c < 3; c++) begin
        sample();
        if (done) done_cnt++;
        tick();
      end
      dm_ack = 1'b0;
      chk("rstreq_no_done", done_cnt, 32'd0);
      chk("rstreq_rdata_cleared", rdata, 32'h0);
      chk("rstreq_idle", {30'h0, dbg_state}, 32'h0);
      run_vec('{1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_5000, 32'h0, 32'h2468_ACE0,
                1'b0, 4'b1111, 32'h0, 32'h2468_ACE0}, 100);
    end

    // Back-to-back LW then SW against a zero-wait memory.
    begin
      int first_done = -1;
      int second_done = -1;
      int done_cnt = 0;
      dm_ack = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (c <= 2) begin
          drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_6000, 32'h0);
          dm_rdata = 32'hCAFE_F00D;
        end else if (c == 3) begin
          drive(1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_6004, 32'h0BAD_BEEF);
          dm_rdata = 32'h5555_5555;
        end else begin
          idle_in();
        end
        sample();
        if (done) begin
          done_cnt++;
          if (first_done < 0) first_done = c;
          else second_done = c;
        end
        if (c == 4) begin
          chk("b2b_sw_we", {31'h0, dm_we}, 32'h1);
          chk("b2b_sw_addr", dm_addr, 32'h0000_6004);
        end
        tick();
      end
      dm_ack = 1'b0;
      chk("b2b_first_done", first_done, 32'd2);
      chk("b2b_second_done", second_done, 32'd5);
      chk("b2b_done_count", done_cnt, 32'd2);
      chk("b2b_rdata_kept", rdata, 32'hCAFE_F00D);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
